round_shift_mix: RTL and testbench
==================================

Name: round_shift_mix

Overview:
- Round stage directly downstream of the SubBytes stage. Takes the four 32-bit substituted state columns and applies ShiftRows then MixColumns.
- MixColumns is column-serial through a small FSM: COLS_PER_CYCLE columns per cycle, reusing that many single-column mixers.
- A valid/ready handshake on both sides lets the stage stall and accept back-pressure from the following AddRoundKey stage.
- A last_round input bypasses MixColumns, as the final AES round requires.

Parameters:
- COLS_PER_CYCLE, 1, number of columns mixed per cycle. Legal values are 1, 2, 4; any other value is an elaboration error. N = 4/COLS_PER_CYCLE.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input columns valid.
- in_ready  out  1  stage can accept; equals (state==IDLE).
- last_round  in  1  sampled with the input; 1 means skip MixColumns.
- in_col0..in_col3  in  32 each  SubBytes output columns 0..3. Byte [31:24] is row 0, [7:0] is row 3.
- out_valid  out  1  result valid; held until consumed.
- out_ready  in  1  downstream accepts.
- out_col0..out_col3  out  32 each  result columns, same byte order as the inputs.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, column counter=0, state register=0, last flag=0. Consequently out_valid=0, out_col*=0, and in_ready=1.
- ShiftRows: for row r of output column c, take row r of input column (c+r) mod 4. Pure wiring, applied at load.
- Mixing, GF(2^8):
  - xtime(b) = {b[6:0],0} ^ (b[7] ? 8'h1B : 0).
  - For column a0..a3: o0=2a0^3a1^a2^a3, o1=a0^2a1^3a2^a3, o2=a0^a1^2a2^3a3, o3=3a0^a1^a2^2a3.
- FSM states: IDLE, MIX, DONE.
  - IDLE: on the edge where in_valid&&in_ready, the shifted state is loaded into the register, last_round is latched, and the counter is cleared. Next state is DONE if last_round=1, else MIX.
  - MIX: each edge replaces columns counter..counter+COLS_PER_CYCLE-1 with their mixed values and adds COLS_PER_CYCLE to the counter. When the final group is written, next state is DONE.
  - DONE: out_valid=1 and out_col* come directly from the register. On the edge where out_ready=1, go to IDLE.
- Latency from the accept edge to out_valid high: N+1 cycles normally, 1 cycle when last_round=1. With COLS_PER_CYCLE=1 that is 5 cycles.
- Throughput: one block per N+2 cycles with out_ready tied high. No accept in the same cycle as output consumption; in_ready rises the cycle after the DONE→IDLE edge.
- Back-pressure: while in DONE with out_ready=0, out_col* and out_valid are held stable indefinitely.
- Input changes: in_col*, last_round and in_valid are ignored whenever in_ready=0.
- The counter wraps only via the state transition; it never indexes past column 3.
- Reset mid-MIX or mid-DONE: immediate return to reset values. The partial result is discarded and out_valid drops asynchronously.
- out_ready while out_valid=0 has no effect.

Optional Feature:
- Macro: SHIFT_MIX_INV_EN.
- Defined: adds input port inv (1 bit), sampled at accept.
  - inv=1 loads the input without shifting.
  - MIX uses InvMixColumns coefficients: o0=14a0^11a1^13a2^9a3, rotated the same way for o1..o3.
  - out_col* then take InvShiftRows of the register (row r of output column c from register column (c−r) mod 4).
  - inv=1 with last_round=1 gives InvShiftRows only.
  - Latency is identical to forward mode.
- Undefined: no inv port and no inverse multipliers; forward behaviour only.

Decomposition:
- Package aes_pkg holds:
  - the xtime function and GF multiply-by-2/3/9/11/13/14 functions;
  - the FSM state encoding (IDLE=2'd0, MIX=2'd1, DONE=2'd2);
  - the constant NUM_COLS=4;
  - the constant AES_POLY=8'h1B.
- One sub-module, mix_single_column: a combinational 32-bit column in/out with an inv select (tied to 0 when SHIFT_MIX_INV_EN is undefined). Instantiated COLS_PER_CYCLE times.

Test Plan:
- FIPS-197 App. B round 1: in_col0..3 = d4271 1ae, e0bf98f1, b8b45de5, 1e415230 (i.e. d42711ae, e0bf98f1, b8b45de5, 1e415230), last_round=0, COLS_PER_CYCLE=1 -> out_col0..3 = 046681e5, e0cb199a, 48f8d37a, 2806264c; out_valid rises exactly 5 cycles after the accept edge.
- Same input with last_round=1 -> out_col0..3 = d4bf5d30, e0b452ae, b84111f1, 1e2798e5; out_valid 1 cycle after accept.
- Single-column vectors: all four columns db135345, f20a225c, 01010101, c6c6c6c6 with last_round=0 -> ShiftRows-consistent result, checked against a reference model; repeat for COLS_PER_CYCLE=2 (latency 3) and COLS_PER_CYCLE=4 (latency 2).
- Back-pressure: out_ready=0 for 6 cycles in DONE -> out_col* stable and out_valid=1 throughout; in_ready=0 and in_valid pulses are ignored; release -> in_ready=1 the next cycle.
- Reset asserted on the 2nd MIX cycle -> out_valid=0 and out_col*=0 immediately, in_ready=1; a fresh accept then yields correct results.
- SHIFT_MIX_INV_EN, inv=1, in_col0..3 = 046681e5, e0cb199a, 48f8d37a, 2806264c -> out_col0..3 = d42711ae, e0bf98f1, b8b45de5, 1e415230.

Source files
------------

// File: rtl/aes_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : aes_pkg                                                      |
// | Description : GF(2^8) helpers, FSM encoding and constants for the AES      |
// |               ShiftRows/MixColumns round stage.                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package aes_pkg;

    localparam int         NUM_COLS = 4;
    localparam logic [7:0] AES_POLY = 8'h1B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MIX  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gmul2(input logic [7:0] b);
        return xtime(b);
    endfunction

    function automatic logic [7:0] gmul3(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] gmul9(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] gmul11(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] gmul13(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] gmul14(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

    // State is {col0,col1,col2,col3}, row 0 in the top byte of each column.
    // Forward: row r of column c comes from column (c+r); inverse from (c-r).
    function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inverse);
        logic [127:0] t;
        int           src;
        t = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            for (int r = 0; r < 4; r++) begin
                src = inverse ? ((c - r + NUM_COLS) % NUM_COLS) : ((c + r) % NUM_COLS);
                t[127 - 32*c - 8*r -: 8] = s[127 - 32*src - 8*r -: 8];
            end
        end
        return t;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mix_single_column.sv
// +----------------------------------------------------------------------------+
// | Module      : mix_single_column                                            |
// | Description : Combinational (Inv)MixColumns on one 32-bit column.          |
// |               Inverse coefficients exist only with SHIFT_MIX_INV_EN.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module mix_single_column
    import aes_pkg::*;
(
    input  logic [31:0] col_in,
    input  logic        inv,
    output logic [31:0] col_out
);

    logic [7:0]  w_a0, w_a1, w_a2, w_a3;
    logic [31:0] w_fwd;

    assign {w_a0, w_a1, w_a2, w_a3} = col_in;

    assign w_fwd = {
        gmul2(w_a0) ^ gmul3(w_a1) ^ w_a2        ^ w_a3,
        w_a0        ^ gmul2(w_a1) ^ gmul3(w_a2) ^ w_a3,
        w_a0        ^ w_a1        ^ gmul2(w_a2) ^ gmul3(w_a3),
        gmul3(w_a0) ^ w_a1        ^ w_a2        ^ gmul2(w_a3)
    };

`ifdef SHIFT_MIX_INV_EN
    logic [31:0] w_inv;

    assign w_inv = {
        gmul14(w_a0) ^ gmul11(w_a1) ^ gmul13(w_a2) ^ gmul9(w_a3),
        gmul9(w_a0)  ^ gmul14(w_a1) ^ gmul11(w_a2) ^ gmul13(w_a3),
        gmul13(w_a0) ^ gmul9(w_a1)  ^ gmul14(w_a2) ^ gmul11(w_a3),
        gmul11(w_a0) ^ gmul13(w_a1) ^ gmul9(w_a2)  ^ gmul14(w_a3)
    };

    assign col_out = inv ? w_inv : w_fwd;
`else
    logic w_unused_inv;

    assign w_unused_inv = inv;
    assign col_out      = w_fwd;
`endif

endmodule

`default_nettype wire

// File: rtl/round_shift_mix.sv
// +----------------------------------------------------------------------------+
// | Module      : round_shift_mix                                              |
// | Description : AES round stage: ShiftRows at load, column-serial            |
// |               MixColumns, valid/ready on both sides, last-round bypass.    |
// |               Optional inverse mode under macro SHIFT_MIX_INV_EN.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module round_shift_mix
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        last_round,
`ifdef SHIFT_MIX_INV_EN
    input  logic        inv,
`endif
    input  logic [31:0] in_col0,
    input  logic [31:0] in_col1,
    input  logic [31:0] in_col2,
    input  logic [31:0] in_col3,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_col0,
    output logic [31:0] out_col1,
    output logic [31:0] out_col2,
    output logic [31:0] out_col3
);

    localparam logic [1:0] c_step     = 2'(COLS_PER_CYCLE % NUM_COLS);
    localparam logic [1:0] c_last_grp = 2'(NUM_COLS - COLS_PER_CYCLE);

    generate
        if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cfg
            $error("round_shift_mix: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    state_t                          r_state;
    logic [1:0]                      r_cnt;
    logic [0:NUM_COLS-1][31:0]       r_cols;
    logic                            r_last;

    logic [127:0]                    w_in;
    logic [127:0]                    w_load;
    logic [127:0]                    w_out;
    logic                            w_inv_sel;
    logic [1:0]                      w_mix_idx [COLS_PER_CYCLE];
    logic [31:0]                     w_mix_out [COLS_PER_CYCLE];

    assign w_in = {in_col0, in_col1, in_col2, in_col3};

`ifdef SHIFT_MIX_INV_EN
    logic r_inv;

    // Inverse blocks load unshifted; InvShiftRows is applied on the way out.
    assign w_load    = inv ? w_in : shift_rows(w_in, 1'b0);
    assign w_inv_sel = r_inv;
    assign w_out     = shift_rows(r_cols, r_inv);
`else
    assign w_load    = shift_rows(w_in, 1'b0);
    assign w_inv_sel = 1'b0;
    assign w_out     = r_cols;
`endif

    generate
        for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_mix
            assign w_mix_idx[k] = r_cnt + 2'(k);

            mix_single_column u_mix (
                .col_in  (r_cols[w_mix_idx[k]]),
                .inv     (w_inv_sel),
                .col_out (w_mix_out[k])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_cols  <= '0;
            r_last  <= 1'b0;
`ifdef SHIFT_MIX_INV_EN
            r_inv   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_cols  <= w_load;
                        r_last  <= last_round;
                        r_cnt   <= '0;
                        r_state <= last_round ? DONE : MIX;
`ifdef SHIFT_MIX_INV_EN
                        r_inv   <= inv;
`endif
                    end
                end
                MIX: begin
                    // A bypass block never needs mixing; leave immediately if one got here.
                    if (r_last) begin
                        r_cnt   <= '0;
                        r_state <= DONE;
                    end else begin
                        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
                            r_cols[w_mix_idx[k]] <= w_mix_out[k];
                        end
                        if (r_cnt == c_last_grp) begin
                            r_cnt   <= '0;
                            r_state <= DONE;
                        end else begin
                            r_cnt   <= r_cnt + c_step;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign {out_col0, out_col1, out_col2, out_col3} = w_out;

endmodule

`default_nettype wire

// File: tb/tb_round_shift_mix.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_round_shift_mix                                           |
// | Description : Randomised self-checking bench for round_shift_mix with      |
// |               COLS_PER_CYCLE = 1, 2 and 4 driven in lockstep.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_round_shift_mix;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         last_round = 1'b0;
    logic         out_ready = 1'b0;
    logic         inv_sel = 1'b0;
    logic [31:0]  c0 = '0, c1 = '0, c2 = '0, c3 = '0;
    logic [2:0]   ir, ov;
    logic [127:0] ob0, ob1, ob2;
    logic [127:0] obs [3];

    int n_checks = 0;
    int n_errors = 0;
    int exp_lat [3] = '{5, 3, 2};

    always #5 clk = ~clk;

    assign obs[0] = ob0;
    assign obs[1] = ob1;
    assign obs[2] = ob2;

    round_shift_mix #(.COLS_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .last_round(last_round),
`ifdef SHIFT_MIX_INV_EN
        .inv(inv_sel),
`endif
        .in_col0(c0), .in_col1(c1), .in_col2(c2), .in_col3(c3),
        .out_valid(ov[0]), .out_ready(out_ready),
        .out_col0(ob0[127:96]), .out_col1(ob0[95:64]), .out_col2(ob0[63:32]), .out_col3(ob0[31:0])
    );

    round_shift_mix #(.COLS_PER_CYCLE(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .last_round(last_round),
`ifdef SHIFT_MIX_INV_EN
        .inv(inv_sel),
`endif
        .in_col0(c0), .in_col1(c1), .in_col2(c2), .in_col3(c3),
        .out_valid(ov[1]), .out_ready(out_ready),
        .out_col0(ob1[127:96]), .out_col1(ob1[95:64]), .out_col2(ob1[63:32]), .out_col3(ob1[31:0])
    );

    round_shift_mix #(.COLS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .last_round(last_round),
`ifdef SHIFT_MIX_INV_EN
        .inv(inv_sel),
`endif
        .in_col0(c0), .in_col1(c1), .in_col2(c2), .in_col3(c3),
        .out_valid(ov[2]), .out_ready(out_ready),
        .out_col0(ob2[127:96]), .out_col1(ob2[95:64]), .out_col2(ob2[63:32]), .out_col3(ob2[31:0])
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Carry-less product reduced modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--)
            if (p[i]) p = p ^ (16'h011B << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [127:0] ref_round(input logic [127:0] blk, input bit last, input bit inverse);
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [7:0]   m [4][4];
        logic [7:0]   coef [4];
        logic [127:0] res;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = blk[127 - 32*c - 8*r -: 8];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                t[r][c] = inverse ? s[r][c] : s[r][(c + r) % 4];
        if (inverse) coef = '{8'd14, 8'd11, 8'd13, 8'd9};
        else         coef = '{8'd2, 8'd3, 8'd1, 8'd1};
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                m[r][c] = 8'h00;
                for (int k = 0; k < 4; k++)
                    m[r][c] = m[r][c] ^ gf_mul(coef[(k - r + 4) % 4], t[k][c]);
                if (last) m[r][c] = t[r][c];
            end
        res = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                res[127 - 32*c - 8*r -: 8] = inverse ? m[r][(c - r + 4) % 4] : m[r][c];
        return res;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_inputs();
        in_valid   = 1'($urandom_range(0, 1));
        last_round = 1'($urandom_range(0, 1));
        inv_sel    = 1'($urandom_range(0, 1));
        {c0, c1, c2, c3} = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic run_block(input logic [127:0] blk, input bit last, input bit inv_i,
                             input int hold, input bit use_fixed, input logic [127:0] fixed_exp);
        logic [127:0] exp;
        int           lat [3];
        int           w;
        w = 0;
        while (ir !== 3'b111 && w < 20) begin
            tick();
            w++;
        end
        check("in_ready_idle", 128'(ir), 128'(3'b111));
        {c0, c1, c2, c3} = blk;
        last_round = last;
        inv_sel    = inv_i;
        in_valid   = 1'b1;
        tick();
        exp = ref_round(blk, last, inv_i);
        lat = '{0, 0, 0};
        for (int cyc = 1; cyc <= 20; cyc++) begin
            scramble_inputs();
            for (int d = 0; d < 3; d++)
                if (lat[d] == 0 && ov[d] === 1'b1) lat[d] = cyc;
            if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0) break;
            tick();
        end
        for (int d = 0; d < 3; d++)
            check($sformatf("latency_dut%0d", d), 128'(lat[d]), 128'(last ? 1 : exp_lat[d]));
        for (int h = 0; h < hold; h++) begin
            tick();
            scramble_inputs();
            check("hold_out_valid", 128'(ov), 128'(3'b111));
            check("hold_in_ready", 128'(ir), 128'(3'b000));
            for (int d = 0; d < 3; d++)
                check($sformatf("hold_data_dut%0d", d), obs[d], exp);
        end
        for (int d = 0; d < 3; d++)
            check($sformatf("result_dut%0d", d), obs[d], exp);
        if (use_fixed) check("known_answer", obs[0], fixed_exp);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("release_in_ready", 128'(ir), 128'(3'b111));
        check("release_out_valid", 128'(ov), 128'(3'b000));
    endtask

    localparam logic [127:0] FIPS_IN   = 128'hd42711ae_e0bf98f1_b8b45de5_1e415230;
    localparam logic [127:0] FIPS_MIX  = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
    localparam logic [127:0] FIPS_LAST = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;

    initial begin
        logic [31:0] pats [4] = '{32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6};
        #12;
        check("reset_out_valid", 128'(ov), 128'(3'b000));
        check("reset_in_ready", 128'(ir), 128'(3'b111));
        for (int d = 0; d < 3; d++)
            check($sformatf("reset_data_dut%0d", d), obs[d], 128'h0);
        rst = 1'b1;
        tick();

        run_block(FIPS_IN, 1'b0, 1'b0, 0, 1'b1, FIPS_MIX);
        run_block(FIPS_IN, 1'b1, 1'b0, 0, 1'b1, FIPS_LAST);
        for (int p = 0; p < 4; p++)
            run_block({pats[p], pats[p], pats[p], pats[p]}, 1'b0, 1'b0, 0, 1'b0, '0);
        run_block(FIPS_IN, 1'b0, 1'b0, 6, 1'b1, FIPS_MIX);

        // Reset during the second MIX cycle of the single-column instance.
        {c0, c1, c2, c3} = FIPS_IN;
        last_round = 1'b0;
        inv_sel    = 1'b0;
        in_valid   = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        #2;
        rst = 1'b0;
        #1;
        check("midreset_out_valid", 128'(ov), 128'(3'b000));
        check("midreset_in_ready", 128'(ir), 128'(3'b111));
        for (int d = 0; d < 3; d++)
            check($sformatf("midreset_data_dut%0d", d), obs[d], 128'h0);
        #2;
        rst = 1'b1;
        tick();
        run_block(FIPS_IN, 1'b0, 1'b0, 0, 1'b1, FIPS_MIX);

        for (int i = 0; i < 20; i++)
            run_block({$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b0,
                      $urandom_range(0, 3), 1'b0, '0);

`ifdef SHIFT_MIX_INV_EN
        run_block(FIPS_MIX, 1'b0, 1'b1, 0, 1'b1, FIPS_IN);
        for (int i = 0; i < 10; i++)
            run_block({$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'b0, '0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
